phy_tx_pack: RTL

- Parametrised TX packer for AD9361-class LVDS DDR interfaces.
- Takes full-width I/Q samples for 1..MAX_CH channels over a valid/ready stream and buffers them in an internal FIFO.
- Slices each sample into LANE_W-bit beats and generates the matching frame signal.
- Outputs registered pos-edge/neg-edge lane words and frame to the existing ODDR/OBUFDS output stage.
- Adds what the previous PHY lacked: backpressure, underrun handling, a runtime channel count, and graceful start/stop.

---
 rtl/phy_tx_pack_if.sv | 12 +
 rtl/phy_tx_pack.sv | 133 +++++++++++++
 2 files changed

// File: rtl/phy_tx_pack_if.sv
// phy_tx_pack_if: valid/ready sample-set stream feeding the TX packer.
interface phy_tx_pack_if #(
  parameter int SAMPLE_W = 12,
  parameter int MAX_CH   = 2
);
  logic                       s_valid;
  logic                       s_ready;
  logic [MAX_CH*SAMPLE_W-1:0] s_data_i;
  logic [MAX_CH*SAMPLE_W-1:0] s_data_q;
  modport master (output s_valid, s_data_i, s_data_q, input s_ready);
  modport slave  (input s_valid, s_data_i, s_data_q, output s_ready);
endinterface

// File: rtl/phy_tx_pack.sv
// phy_tx_pack: buffered I/Q to LVDS DDR lane packer with frame, underrun fill and graceful stop.
// Optional ramp test pattern (input i_pattern_en) is built when PHY_TX_PATTERN_EN is defined.
module phy_tx_pack #(
  parameter int SAMPLE_W   = 12,
  parameter int LANE_W     = 6,
  parameter int MAX_CH     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     data_clk,
  input  logic                     rst,
  input  logic                     i_enable,
  input  logic [$clog2(MAX_CH):0]  i_ch_num,
`ifdef PHY_TX_PATTERN_EN
  input  logic                     i_pattern_en,
`endif
  phy_tx_pack_if.slave             s,
  output logic                     o_tx_frame,
  output logic [LANE_W-1:0]        o_tx_data_pos,
  output logic [LANE_W-1:0]        o_tx_data_neg,
  output logic                     o_busy,
  output logic                     o_underrun,
  output logic [15:0]              o_underrun_cnt
);
  localparam int BEATS = SAMPLE_W / LANE_W;
  localparam int DW    = MAX_CH * SAMPLE_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(MAX_CH) + 1;
  localparam int SW    = $clog2(BEATS) + 1;
  localparam int BW    = $clog2(BEATS * MAX_CH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  logic [DW-1:0] r_mem_i [FIFO_DEPTH];
  logic [DW-1:0] r_mem_q [FIFO_DEPTH];
  logic [AW:0]   r_wp, r_rp;
  logic [1:0]    r_state;
  logic [CW-1:0] r_nch, r_ch;
  logic [SW-1:0] r_sl;
  logic [BW-1:0] r_beat;
  logic [DW-1:0] r_si, r_sq;
  logic          w_empty, w_full, w_pat, w_last, w_start, w_pop, w_push, w_act, w_frame, w_fill0;
  logic [CW-1:0] w_nch;
  logic [DW-1:0] w_nxt_i, w_nxt_q;
  logic [31:0]   w_sh;
  assign w_empty = r_wp == r_rp;
  assign w_full  = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign w_nch   = (i_ch_num == '0 || i_ch_num > CW'(MAX_CH)) ? CW'(1) : i_ch_num;
  assign w_last  = (r_ch == r_nch - CW'(1)) && (r_sl == SW'(BEATS - 1));
  assign w_start = i_enable && ((r_state == S_IDLE) ? (w_pat || !w_empty) : w_last);
  assign w_pop   = w_start && !w_pat && !w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign s.s_ready = !w_pat && (!w_full || w_pop);
  assign w_push  = s.s_valid && s.s_ready;
  assign w_act   = r_state != S_IDLE;
  assign o_busy  = w_act;
  assign w_sh    = 32'(r_ch) * SAMPLE_W + (BEATS - 1 - 32'(r_sl)) * LANE_W;
  assign w_frame = ((32'(r_beat) + 32'd1) << 1) <= BEATS * 32'(r_nch);
  assign w_fill0 = r_state == S_FILL && r_beat == '0;
`ifdef PHY_TX_PATTERN_EN
  logic [SAMPLE_W-1:0] r_ramp;
  logic [DW-1:0]       w_ri, w_rq;
  assign w_pat = i_pattern_en;
  always_comb begin
    w_ri = '0;
    w_rq = '0;
    for (int k = 0; k < MAX_CH; k++) begin
      w_ri[k*SAMPLE_W +: SAMPLE_W] = r_ramp + SAMPLE_W'(k);
      w_rq[k*SAMPLE_W +: SAMPLE_W] = ~(r_ramp + SAMPLE_W'(k));
    end
  end
  assign w_nxt_i = w_pat ? w_ri : w_pop ? r_mem_i[r_rp[AW-1:0]] : '0;
  assign w_nxt_q = w_pat ? w_rq : w_pop ? r_mem_q[r_rp[AW-1:0]] : '0;
  always_ff @(posedge data_clk or posedge rst)
    if (rst) r_ramp <= '0;
    else if (w_start && w_pat) r_ramp <= r_ramp + SAMPLE_W'(1);
`else
  assign w_pat   = 1'b0;
  assign w_nxt_i = w_pop ? r_mem_i[r_rp[AW-1:0]] : '0;
  assign w_nxt_q = w_pop ? r_mem_q[r_rp[AW-1:0]] : '0;
`endif
  always_ff @(posedge data_clk)
    if (w_push) begin
      r_mem_i[r_wp[AW-1:0]] <= s.s_data_i;
      r_mem_q[r_wp[AW-1:0]] <= s.s_data_q;
    end
  always_ff @(posedge data_clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_wp <= r_wp + (AW+1)'(w_push);
      r_rp <= r_rp + (AW+1)'(w_pop);
    end
  // Period sequencer; an empty FIFO at a period start yields a zero-filled period.
  always_ff @(posedge data_clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_nch   <= CW'(1);
      r_ch    <= '0;
      r_sl    <= '0;
      r_beat  <= '0;
      r_si    <= '0;
      r_sq    <= '0;
    end else if (w_start) begin
      r_state <= (w_pat || !w_empty) ? S_RUN : S_FILL;
      r_nch   <= w_nch;
      r_ch    <= '0;
      r_sl    <= '0;
      r_beat  <= '0;
      r_si    <= w_nxt_i;
      r_sq    <= w_nxt_q;
    end else if (w_act && w_last) begin
      r_state <= S_IDLE;
    end else if (w_act) begin
      r_beat <= r_beat + BW'(1);
      r_sl   <= (r_sl == SW'(BEATS - 1)) ? '0 : r_sl + SW'(1);
      r_ch   <= (r_sl == SW'(BEATS - 1)) ? r_ch + CW'(1) : r_ch;
    end
  always_ff @(posedge data_clk or posedge rst)
    if (rst) begin
      o_tx_frame     <= 1'b0;
      o_tx_data_pos  <= '0;
      o_tx_data_neg  <= '0;
      o_underrun     <= 1'b0;
      o_underrun_cnt <= '0;
    end else begin
      o_tx_frame     <= w_act && w_frame;
      o_tx_data_pos  <= w_act ? LANE_W'(r_si >> w_sh) : '0;
      o_tx_data_neg  <= w_act ? LANE_W'(r_sq >> w_sh) : '0;
      o_underrun     <= w_fill0;
      o_underrun_cnt <= (w_fill0 && o_underrun_cnt != 16'hFFFF) ? o_underrun_cnt + 16'd1 : o_underrun_cnt;
    end
endmodule
